// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_responder
//  Purpose  : Memory-side responder for the cache bridge request interface.
//             Serves reads (rd_req/rd_rdy, returned as ret_valid/ret_last
//             beats) and writes (wr_req/wr_rdy) from a single cache instance.
//             Backed by an internal word-addressed memory with programmable
//             read and write latencies. Supports single-word and 4-word line
//             transfers, and keeps same-line reads and writes apart.
//
//  Ports    : clk          clock, all state updates on posedge
//             reset        synchronous, active-high
//             i_rd_req     read request valid
//             i_rd_type    000 byte, 001 half, 010 word, 100 line (else word)
//             i_rd_addr    read byte address
//             o_rd_rdy     read request may be accepted this cycle
//             o_ret_valid  read data beat valid
//             o_ret_last   final beat of the current read
//             o_ret_data   read data beat (0 when o_ret_valid=0)
//             i_wr_req     write request valid
//             i_wr_type    encoded as i_rd_type
//             i_wr_addr    write byte address
//             i_wr_strb    byte enables for non-line writes
//             i_wr_data    write data; [31:0] only for non-line writes
//             o_wr_rdy     write request may be accepted this cycle
//
//  Revision : 1.0  initial release
// ============================================================================
module cache_mem_responder #(
   parameter int MEM_AW = 12,   // log2 of memory depth in 32-bit words
   parameter int RD_LAT = 2,    // accept -> first beat, 1..15
   parameter int WR_LAT = 2     // accept -> commit, 1..15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_rd_req,
   input  logic [2:0]    i_rd_type,
   input  logic [31:0]   i_rd_addr,
   output logic          o_rd_rdy,
   output logic          o_ret_valid,
   output logic          o_ret_last,
   output logic [31:0]   o_ret_data,
   input  logic          i_wr_req,
   input  logic [2:0]    i_wr_type,
   input  logic [31:0]   i_wr_addr,
   input  logic [3:0]    i_wr_strb,
   input  logic [127:0]  i_wr_data,
   output logic          o_wr_rdy
);

   localparam logic [2:0] c_TYPE_LINE = 3'b100;
   localparam int         c_DEPTH     = 1 << MEM_AW;
   localparam int         c_LW        = MEM_AW - 2;   // line index width

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_BEAT = 2'd2} rstate_t;
   typedef enum logic       {W_IDLE = 1'b0, W_BUSY = 1'b1} wstate_t;

   // ------------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------------
   logic [31:0]        r_mem [0:c_DEPTH-1];

   rstate_t            r_rstate;
   logic [3:0]         r_rcnt;
   logic [1:0]         r_rbeat;
   logic               r_rline_mode;
   logic [MEM_AW-1:0]  r_rword;       // base word (line reads: [1:0]=00)

   wstate_t            r_wstate;
   logic [3:0]         r_wcnt;
   logic               r_wline_mode;
   logic [MEM_AW-1:0]  r_wword;
   logic [3:0]         r_wstrb;
   logic [127:0]       r_wdata;

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   logic [c_LW-1:0]    w_rd_line;
   logic [c_LW-1:0]    w_wr_line;
   logic               w_rd_is_line;
   logic               w_wr_is_line;
   logic               w_commit;
   logic [MEM_AW-1:0]  w_rd_word;
   logic               w_unused;

   assign w_rd_line    = i_rd_addr[MEM_AW+1:4];
   assign w_wr_line    = i_wr_addr[MEM_AW+1:4];
   assign w_rd_is_line = (i_rd_type == c_TYPE_LINE);
   assign w_wr_is_line = (i_wr_type == c_TYPE_LINE);

   // Upper address bits alias; byte offset is resolved by the requester.
   assign w_unused = ^{i_rd_addr[31:MEM_AW+2], i_rd_addr[1:0],
                       i_wr_addr[31:MEM_AW+2], i_wr_addr[1:0]};

   // ------------------------------------------------------------------------
   // Ready logic. A read may not start on a line with a pending write, and
   // a write arriving together with a same-line read takes priority. A
   // write may not start on the line currently being read.
   // ------------------------------------------------------------------------
   assign o_wr_rdy = (r_wstate == W_IDLE) && !reset &&
                     !((r_rstate != R_IDLE) && (w_wr_line == r_rword[MEM_AW-1:2]));

   assign o_rd_rdy = (r_rstate == R_IDLE) && !reset &&
                     !((r_wstate == W_BUSY) && (w_rd_line == r_wword[MEM_AW-1:2])) &&
                     !(i_wr_req && o_wr_rdy && (w_rd_line == w_wr_line));

   // ------------------------------------------------------------------------
   // Return path: memory is read combinationally on each beat cycle
   // ------------------------------------------------------------------------
   assign w_rd_word   = r_rline_mode ? {r_rword[MEM_AW-1:2], r_rbeat} : r_rword;
   assign o_ret_valid = (r_rstate == R_BEAT) && !reset;
   assign o_ret_last  = o_ret_valid && (!r_rline_mode || (r_rbeat == 2'd3));
   assign o_ret_data  = o_ret_valid ? r_mem[w_rd_word] : 32'd0;

   // ------------------------------------------------------------------------
   // Read FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rstate     <= R_IDLE;
         r_rcnt       <= 4'd0;
         r_rbeat      <= 2'd0;
         r_rline_mode <= 1'b0;
         r_rword      <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (i_rd_req && o_rd_rdy) begin
                  r_rstate     <= R_WAIT;
                  r_rcnt       <= 4'(RD_LAT - 1);
                  r_rbeat      <= 2'd0;
                  r_rline_mode <= w_rd_is_line;
                  r_rword      <= w_rd_is_line ? {w_rd_line, 2'b00}
                                               : i_rd_addr[MEM_AW+1:2];
               end
            end
            R_WAIT: begin
               if (r_rcnt == 4'd0) r_rstate <= R_BEAT;
               else                r_rcnt   <= r_rcnt - 4'd1;
            end
            R_BEAT: begin
               r_rbeat <= r_rbeat + 2'd1;
               if (o_ret_last) r_rstate <= R_IDLE;
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Write FSM
   // ------------------------------------------------------------------------
   assign w_commit = (r_wstate == W_BUSY) && (r_wcnt == 4'd0) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wstate     <= W_IDLE;
         r_wcnt       <= 4'd0;
         r_wline_mode <= 1'b0;
         r_wword      <= '0;
         r_wstrb      <= 4'd0;
         r_wdata      <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (i_wr_req && o_wr_rdy) begin
                  r_wstate     <= W_BUSY;
                  r_wcnt       <= 4'(WR_LAT - 1);
                  r_wline_mode <= w_wr_is_line;
                  r_wword      <= w_wr_is_line ? {w_wr_line, 2'b00}
                                               : i_wr_addr[MEM_AW+1:2];
                  r_wstrb      <= i_wr_strb;
                  r_wdata      <= i_wr_data;
               end
            end
            W_BUSY: begin
               if (r_wcnt == 4'd0) r_wstate <= W_IDLE;
               else                r_wcnt   <= r_wcnt - 4'd1;
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // Memory array has no reset; contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         if (r_wline_mode) begin
            for (int k = 0; k < 4; k++) begin
               r_mem[{r_wword[MEM_AW-1:2], 2'(k)}] <= r_wdata[32*k +: 32];
            end
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (r_wstrb[b]) r_mem[r_wword][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_mem_responder
//  Purpose  : Directed self-checking bench for cache_mem_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_mem_responder;

   localparam int RD_LAT = 2;
   localparam int WR_LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_rd_req;
   logic [2:0]    i_rd_type;
   logic [31:0]   i_rd_addr;
   logic          o_rd_rdy;
   logic          o_ret_valid;
   logic          o_ret_last;
   logic [31:0]   o_ret_data;
   logic          i_wr_req;
   logic [2:0]    i_wr_type;
   logic [31:0]   i_wr_addr;
   logic [3:0]    i_wr_strb;
   logic [127:0]  i_wr_data;
   logic          o_wr_rdy;

   int n_cmp = 0;
   int n_err = 0;

   cache_mem_responder #(.MEM_AW(12), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_rd_req    (i_rd_req),
      .i_rd_type   (i_rd_type),
      .i_rd_addr   (i_rd_addr),
      .o_rd_rdy    (o_rd_rdy),
      .o_ret_valid (o_ret_valid),
      .o_ret_last  (o_ret_last),
      .o_ret_data  (o_ret_data),
      .i_wr_req    (i_wr_req),
      .i_wr_type   (i_wr_type),
      .i_wr_addr   (i_wr_addr),
      .i_wr_strb   (i_wr_strb),
      .i_wr_data   (i_wr_data),
      .o_wr_rdy    (o_wr_rdy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue a write, wait for acceptance and commit, then confirm wr_rdy is back.
   task automatic wr_do(input string tag, input logic [2:0] typ, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [127:0] data);
      int n;
      i_wr_req = 1'b1; i_wr_type = typ; i_wr_addr = addr;
      i_wr_strb = strb; i_wr_data = data;
      #1;
      n = 0;
      while (!o_wr_rdy && n < 20) begin tick(); n++; end
      chk({tag, "/wr_rdy"}, {31'd0, o_wr_rdy}, 32'd1);
      tick();
      i_wr_req = 1'b0;
      repeat (WR_LAT) tick();
      chk({tag, "/wr_rdy_after"}, {31'd0, o_wr_rdy}, 32'd1);
   endtask

   // Issue a read and check stall count (returned), latency and every beat.
   task automatic rd_chk(input string tag, input logic [2:0] typ, input logic [31:0] addr,
                         input int nb, input logic [127:0] exp, output int stalls);
      int lat;
      i_rd_req = 1'b1; i_rd_type = typ; i_rd_addr = addr;
      #1;
      stalls = 0;
      while (!o_rd_rdy && stalls < 20) begin tick(); stalls++; end
      chk({tag, "/rd_rdy"}, {31'd0, o_rd_rdy}, 32'd1);
      tick();
      i_rd_req = 1'b0;
      i_wr_req = 1'b0;
      lat = 0;
      while (!o_ret_valid && lat < 20) begin tick(); lat++; end
      chk({tag, "/latency"}, 32'(lat), 32'(RD_LAT));
      for (int b = 0; b < nb; b++) begin
         chk({tag, "/valid"}, {31'd0, o_ret_valid}, 32'd1);
         chk({tag, "/data"}, o_ret_data, exp[32*b +: 32]);
         chk({tag, "/last"}, {31'd0, o_ret_last}, (b == nb - 1) ? 32'd1 : 32'd0);
         tick();
      end
      chk({tag, "/valid_end"}, {31'd0, o_ret_valid}, 32'd0);
      chk({tag, "/data_end"}, o_ret_data, 32'd0);
      chk({tag, "/rd_rdy_end"}, {31'd0, o_rd_rdy}, 32'd1);
   endtask

   localparam logic [127:0] c_L40  = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] c_L100 = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
   localparam logic [127:0] c_L500 = 128'h55550003_55550002_55550001_55550000;
   localparam logic [127:0] c_L200 = 128'h20000003_20000002_20000001_20000000;
   localparam logic [127:0] c_L300 = 128'h30000003_30000002_30000001_30000000;

   initial begin
      int st;
      reset = 1'b1;
      i_rd_req = 1'b0; i_rd_type = 3'b010; i_rd_addr = 32'd0;
      i_wr_req = 1'b0; i_wr_type = 3'b010; i_wr_addr = 32'd0;
      i_wr_strb = 4'h0; i_wr_data = '0;

      // Reset state
      repeat (3) tick();
      chk("rst/rd_rdy", {31'd0, o_rd_rdy}, 32'd0);
      chk("rst/wr_rdy", {31'd0, o_wr_rdy}, 32'd0);
      chk("rst/valid", {31'd0, o_ret_valid}, 32'd0);
      chk("rst/data", o_ret_data, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst/rd_rdy_rel", {31'd0, o_rd_rdy}, 32'd1);
      chk("rst/wr_rdy_rel", {31'd0, o_wr_rdy}, 32'd1);
      tick();

      // 1: line write then line read from mid-line address
      wr_do("t1w", 3'b100, 32'h0000_0040, 4'hF, c_L40);
      rd_chk("t1r", 3'b100, 32'h0000_0048, 4, c_L40, st);
      chk("t1/stalls", 32'(st), 32'd0);

      // 2: byte-strobed word write
      wr_do("t2a", 3'b010, 32'h0000_0048, 4'hF, {96'd0, 32'h11223344});
      wr_do("t2b", 3'b010, 32'h0000_0048, 4'b0101, {96'd0, 32'hAABBCCDD});
      rd_chk("t2r", 3'b010, 32'h0000_0048, 1, {96'd0, 32'h11BB33DD}, st);

      // 3: read held behind a pending same-line write
      i_wr_req = 1'b1; i_wr_type = 3'b100; i_wr_addr = 32'h0000_0100;
      i_wr_strb = 4'hF; i_wr_data = c_L100;
      #1;
      chk("t3/wr_rdy", {31'd0, o_wr_rdy}, 32'd1);
      tick();
      i_wr_req = 1'b0;
      rd_chk("t3r", 3'b010, 32'h0000_0104, 1, {96'd0, 32'hBBBB0001}, st);
      chk("t3/stalls", 32'(st), 32'(WR_LAT));

      // 3b: simultaneous same-line read and write; write wins
      i_wr_req = 1'b1; i_wr_type = 3'b100; i_wr_addr = 32'h0000_0500;
      i_wr_strb = 4'hF; i_wr_data = c_L500;
      i_rd_req = 1'b1; i_rd_type = 3'b010; i_rd_addr = 32'h0000_050C;
      #1;
      chk("t3b/rd_rdy", {31'd0, o_rd_rdy}, 32'd0);
      chk("t3b/wr_rdy", {31'd0, o_wr_rdy}, 32'd1);
      tick();
      i_wr_req = 1'b0;
      rd_chk("t3br", 3'b010, 32'h0000_050C, 1, {96'd0, 32'h55550003}, st);
      chk("t3b/stalls", 32'(st), 32'(WR_LAT));

      // 4: simultaneous read/write to different lines
      wr_do("t4pre", 3'b100, 32'h0000_0200, 4'hF, c_L200);
      i_wr_req = 1'b1; i_wr_type = 3'b100; i_wr_addr = 32'h0000_0300;
      i_wr_strb = 4'hF; i_wr_data = c_L300;
      i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h0000_0200;
      #1;
      chk("t4/rd_rdy", {31'd0, o_rd_rdy}, 32'd1);
      chk("t4/wr_rdy", {31'd0, o_wr_rdy}, 32'd1);
      rd_chk("t4r", 3'b100, 32'h0000_0200, 4, c_L200, st);
      chk("t4/stalls", 32'(st), 32'd0);
      rd_chk("t4w", 3'b100, 32'h0000_0300, 4, c_L300, st);

      // 5: byte read returns the full aligned word
      rd_chk("t5", 3'b000, 32'h0000_0043, 1, {96'd0, 32'h11111111}, st);

      // 6: reset during a line read and an uncommitted write
      wr_do("t6pre", 3'b010, 32'h0000_0080, 4'hF, {96'd0, 32'hCAFEF00D});
      i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h0000_0040;
      #1;
      chk("t6/rd_rdy", {31'd0, o_rd_rdy}, 32'd1);
      tick();
      i_rd_req = 1'b0;
      tick();
      tick();
      chk("t6/beat0", o_ret_data, 32'h11111111);
      i_wr_req = 1'b1; i_wr_type = 3'b010; i_wr_addr = 32'h0000_0080;
      i_wr_strb = 4'hF; i_wr_data = {96'd0, 32'hDEADBEEF};
      #1;
      chk("t6/wr_rdy", {31'd0, o_wr_rdy}, 32'd1);
      tick();
      i_wr_req = 1'b0;
      chk("t6/beat1", o_ret_data, 32'h22222222);
      chk("t6/beat1_last", {31'd0, o_ret_last}, 32'd0);
      reset = 1'b1;
      #1;
      chk("t6/rst_valid", {31'd0, o_ret_valid}, 32'd0);
      chk("t6/rst_last", {31'd0, o_ret_last}, 32'd0);
      chk("t6/rst_data", o_ret_data, 32'd0);
      chk("t6/rst_rd_rdy", {31'd0, o_rd_rdy}, 32'd0);
      chk("t6/rst_wr_rdy", {31'd0, o_wr_rdy}, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("t6/rel_rd_rdy", {31'd0, o_rd_rdy}, 32'd1);
      chk("t6/rel_wr_rdy", {31'd0, o_wr_rdy}, 32'd1);
      chk("t6/no_beat2", {31'd0, o_ret_valid}, 32'd0);
      tick();
      chk("t6/no_beat3", {31'd0, o_ret_valid}, 32'd0);
      tick();
      chk("t6/quiet", {31'd0, o_ret_valid}, 32'd0);
      rd_chk("t6mem", 3'b010, 32'h0000_0080, 1, {96'd0, 32'hCAFEF00D}, st);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
Memory-side responder for the cache's bridge request interface: it answers rd_req/rd_rdy/ret_valid/ret_last reads and wr_req/wr_rdy writes from one cache instance.
It is backed by an internal word-addressed memory with programmable read and write latencies.
It stands in for the AXI bridge plus memory in block-level cache simulation and in small FPGA builds.
It supports single-word and 4-word line transfers and resolves same-line read/write hazards.

Parameters:
MEM_AW, 12, log2 of memory depth in 32-bit words (4096 words = 16 KB); address bits above MEM_AW+1 are ignored (aliasing).
RD_LAT, 2, cycles from read accept to first ret_valid beat; legal range 1..15.
WR_LAT, 2, cycles from write accept to memory commit; legal range 1..15.

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
rd_req  in  1  read request valid
rd_type  in  3  000 byte, 001 half, 010 word, 100 line; any other code is treated as word
rd_addr  in  32  read byte address
rd_rdy  out  1  read request may be accepted this cycle
ret_valid  out  1  read data beat valid
ret_last  out  1  final beat of the current read
ret_data  out  32  read data beat
wr_req  in  1  write request valid
wr_type  in  3  encoded as rd_type
wr_addr  in  32  write byte address
wr_strb  in  4  byte enables for non-line writes
wr_data  in  128  write data; bits [31:0] are the only data used for non-line writes
wr_rdy  out  1  write request may be accepted this cycle

Behaviour:
- Handshake acceptance:
  - A read is accepted on a cycle with rd_req && rd_rdy; a write is accepted on a cycle with wr_req && wr_rdy.
  - All request fields are captured on the accept cycle.
  - Requesters may hold a request for any time before ready; there is no ret back-pressure.
- Line index: line(addr) = addr[MEM_AW+1:4]. Word index: word(addr) = addr[MEM_AW+1:2].
- Read FSM, states R_IDLE, R_WAIT, R_BEAT:
  - R_IDLE -> R_WAIT on accept; the latency counter is loaded with RD_LAT-1.
  - R_WAIT decrements the counter each cycle and moves to R_BEAT when it reaches 0. The first ret_valid is therefore exactly RD_LAT cycles after the accept edge.
  - Line read: base word = addr with [3:2] forced to 00. Four consecutive beats return words 0,1,2,3. ret_last=1 only on beat 3. The 2-bit beat counter is cleared on accept.
  - Non-line read: one beat carrying the full aligned word that contains the address; the requester selects bytes. ret_last=1 on that beat.
  - R_BEAT -> R_IDLE on the ret_last cycle.
  - The memory word is read combinationally on each beat cycle, not at accept.
  - ret_data is 0 whenever ret_valid=0.
- Write FSM, states W_IDLE, W_BUSY:
  - W_IDLE -> W_BUSY on accept; the counter is loaded with WR_LAT-1.
  - Memory commits on the W_BUSY edge where the counter is 0, then W_BUSY -> W_IDLE.
  - Line write: the four words are written with all bytes enabled; word k receives wr_data[32k+31:32k].
  - Non-line write: word(addr) is written with per-byte wr_strb from wr_data[31:0]; wr_strb is not checked against wr_type.
- Ready rules:
  - rd_rdy = R_IDLE && !reset && !(W_BUSY && line(rd_addr)==pending write line) && !(wr_req && wr_rdy && line(rd_addr)==line(wr_addr)).
  - wr_rdy = W_IDLE && !reset && !(read in R_WAIT/R_BEAT && line(wr_addr)==active read line).
  - Consequence: a read never observes a half-committed line, and a write never changes a line mid-read.
- Simultaneous requests:
  - Read and write to different lines: both are accepted the same cycle and the FSMs run concurrently.
  - Read and write to the same line: the write wins and the read stalls until the cycle after commit.
- Back-to-back operation:
  - rd_rdy is high again the cycle after ret_last, so a new read accepted then gives its first beat RD_LAT cycles later.
  - wr_rdy is high the cycle after commit.
- Reset:
  - While reset=1, all outputs are 0. rd_rdy and wr_rdy are 1 on the first cycle after reset drops.
  - Reset mid-operation aborts in-flight reads (no further beats) and drops any uncommitted write (memory unchanged).
  - Memory contents are not cleared by reset.

Test Plan:
1. Line write 0x00000040, data 128'h44444444_33333333_22222222_11111111, then line read 0x00000048 with RD_LAT=2 -> beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; first beat 2 cycles after accept; ret_last only on the 4th.
2. Word at 0x00000048 = 0x11223344, then write wr_type 010, wr_strb 0101, data 0xAABBCCDD -> after commit, a word read returns 0x11BB33DD.
3. Line write to 0x100 accepted at cycle t, rd_req 0x104 held from t+1 -> rd_rdy=0 through the commit cycle t+WR_LAT, accepted at t+WR_LAT+1, returns the new data.
4. rd_req 0x200 and wr_req 0x300 asserted together from idle -> both accepted the same cycle; read data is the pre-existing 0x200 line.
5. rd_type 000 at 0x00000043 -> one beat with ret_valid=ret_last=1 and the full word at 0x40.
6. Reset asserted after the 2nd beat of a line read and during W_BUSY of a write to 0x80 -> no 3rd beat, memory at 0x80 unchanged, rd_rdy=wr_rdy=1 one cycle after reset deasserts.
